// File: rtl/regbank_wb_sched_pkg.sv
// rtl/regbank_wb_sched_pkg.sv - shared encodings for the register-bank write-back scheduler
package regbank_wb_sched_pkg;

    // Write-data mux selector encodings (mux inputs 0..7).
    typedef enum logic [2:0] {
        SEL_ALU   = 3'd0,
        SEL_MEM   = 3'd1,
        SEL_IMM   = 3'd2,
        SEL_PC4   = 3'd3,
        SEL_LUI   = 3'd4,
        SEL_SHIFT = 3'd5,
        SEL_CSR   = 3'd6,
        SEL_SP    = 3'd7
    } wd_sel_e;

    // Stack pointer register and the constant presented on mux input SEL_SP.
    localparam logic [4:0] SP_REG  = 5'd29;
    localparam logic [7:0] SP_INIT = 8'd227;

    typedef enum logic {
        ST_INIT_SP = 1'b0,
        ST_RUN     = 1'b1
    } state_e;

    // A granted write reaches the bank only for a real source and a
    // non-zero destination; otherwise the grant is consumed silently.
    function automatic logic wb_writes(input logic [2:0] sel, input logic [4:0] dst);
        return (sel != 3'(SEL_SP)) && (dst != 5'd0);
    endfunction

endpackage

// File: rtl/regbank_wb_sched_if.sv
// rtl/regbank_wb_sched_if.sv - requester and register-bank signals of the write-back scheduler
//  ctrl_req/ctrl_src/ctrl_dst/ctrl_ack : control-unit write request and combinational grant
//  ld_issue/ld_dst/ld_ready            : load issue and slot availability
//  wd_sel/rf_dst/rf_we                 : registered register-bank write controls
//  init_busy                           : $sp init write pending
interface regbank_wb_sched_if;

    logic       ctrl_req;
    logic [2:0] ctrl_src;
    logic [4:0] ctrl_dst;
    logic       ctrl_ack;
    logic       ld_issue;
    logic [4:0] ld_dst;
    logic       ld_ready;
    logic [2:0] wd_sel;
    logic [4:0] rf_dst;
    logic       rf_we;
    logic       init_busy;

    // Requester / register-bank side.
    modport master (
        output ctrl_req, ctrl_src, ctrl_dst, ld_issue, ld_dst,
        input  ctrl_ack, ld_ready, wd_sel, rf_dst, rf_we, init_busy
    );

    // Scheduler side.
    modport slave (
        input  ctrl_req, ctrl_src, ctrl_dst, ld_issue, ld_dst,
        output ctrl_ack, ld_ready, wd_sel, rf_dst, rf_we, init_busy
    );

endinterface

// File: rtl/regbank_wb_sched_ld_slot_timer.sv
// rtl/regbank_wb_sched_ld_slot_timer.sv - single outstanding-load slot with latency down-counter
//  clk, reset : clock, synchronous active-high reset
//  accept     : load accepted this cycle (caller guarantees ready)
//  dst_in     : destination of the accepted load
//  expiring   : load data is due; the slot is granted and clears this cycle
//  ready      : no load outstanding
//  dst        : destination of the outstanding load
module regbank_wb_sched_ld_slot_timer #(
    parameter int unsigned MEM_LAT = 2    // legal 1..7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       accept,
    input  logic [4:0] dst_in,
    output logic       expiring,
    output logic       ready,
    output logic [4:0] dst
);

    logic       pending;
    logic [2:0] cnt;
    logic [4:0] dst_q;

    // Counter is loaded with MEM_LAT and the slot is due when it reaches 1,
    // i.e. exactly MEM_LAT cycles after the accepting cycle.
    assign expiring = pending && (cnt == 3'd1);
    assign ready    = !pending;
    assign dst      = dst_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            cnt     <= 3'd0;
            dst_q   <= 5'd0;
        end else if (expiring) begin
            // Load data always wins arbitration, so expiry is always a grant.
            pending <= 1'b0;
            cnt     <= 3'd0;
        end else if (accept) begin
            pending <= 1'b1;
            cnt     <= 3'(MEM_LAT);
            dst_q   <= dst_in;
        end else if (pending) begin
            cnt     <= cnt - 3'd1;
        end
    end

endmodule

// File: rtl/regbank_wb_sched.sv
// rtl/regbank_wb_sched.sv - register-bank write-back scheduler: $sp init, then load/ctrl arbitration
//  clk   : clock, all state on rising edge
//  reset : synchronous, active-high
//  bus   : requester handshakes and registered write controls (regbank_wb_sched_if.slave)
module regbank_wb_sched
    import regbank_wb_sched_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2,   // legal 1..7
    parameter logic [4:0]  SP_REG  = regbank_wb_sched_pkg::SP_REG,
    parameter logic [2:0]  SEL_MEM = 3'(regbank_wb_sched_pkg::SEL_MEM),
    parameter logic [2:0]  SEL_SP  = 3'(regbank_wb_sched_pkg::SEL_SP)
) (
    input  logic                 clk,
    input  logic                 reset,
    regbank_wb_sched_if.slave    bus
);

    state_e     state, state_nxt;
    logic [2:0] wd_sel_q, wd_sel_nxt;
    logic [4:0] rf_dst_q, rf_dst_nxt;
    logic       rf_we_q, rf_we_nxt;

    logic       run;
    logic       ld_expiring;
    logic       slot_ready;
    logic [4:0] slot_dst;
    logic       ld_accept;
    logic       ctrl_grant;

    assign run        = (state == ST_RUN);
    // Expiring load owns the write port; a stalled ctrl request waits.
    assign ctrl_grant = run && bus.ctrl_req && !ld_expiring;
    assign ld_accept  = bus.ld_issue && bus.ld_ready;

    // Handshakes are forced idle while reset is asserted, before the
    // state register has been re-initialised.
    assign bus.ctrl_ack  = ctrl_grant && !reset;
    assign bus.ld_ready  = run && slot_ready && !reset;
    assign bus.init_busy = reset || (state == ST_INIT_SP);
    assign bus.wd_sel    = wd_sel_q;
    assign bus.rf_dst    = rf_dst_q;
    assign bus.rf_we     = rf_we_q;

    regbank_wb_sched_ld_slot_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_ld_slot (
        .clk      (clk),
        .reset    (reset),
        .accept   (ld_accept),
        .dst_in   (bus.ld_dst),
        .expiring (ld_expiring),
        .ready    (slot_ready),
        .dst      (slot_dst)
    );

    always_comb begin
        state_nxt  = state;
        wd_sel_nxt = wd_sel_q;
        rf_dst_nxt = rf_dst_q;
        rf_we_nxt  = 1'b0;
        case (state)
            ST_INIT_SP: begin
                wd_sel_nxt = SEL_SP;
                rf_dst_nxt = SP_REG;
                rf_we_nxt  = 1'b1;
                state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                // Dropped grants (dst 0, reserved source) leave the
                // selector and address untouched.
                if (ld_expiring) begin
                    if (wb_writes(SEL_MEM, slot_dst)) begin
                        wd_sel_nxt = SEL_MEM;
                        rf_dst_nxt = slot_dst;
                        rf_we_nxt  = 1'b1;
                    end
                end else if (ctrl_grant) begin
                    if (wb_writes(bus.ctrl_src, bus.ctrl_dst)) begin
                        wd_sel_nxt = bus.ctrl_src;
                        rf_dst_nxt = bus.ctrl_dst;
                        rf_we_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_INIT_SP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT_SP;
            wd_sel_q <= 3'd0;
            rf_dst_q <= 5'd0;
            rf_we_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wd_sel_q <= wd_sel_nxt;
            rf_dst_q <= rf_dst_nxt;
            rf_we_q  <= rf_we_nxt;
        end
    end

endmodule

// File: tb/tb_regbank_wb_sched.sv
// tb/tb_regbank_wb_sched.sv - directed self-checking bench for regbank_wb_sched
module tb_regbank_wb_sched;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regbank_wb_sched_if bus();

    regbank_wb_sched #(
        .MEM_LAT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Inputs change and outputs are sampled 2 time units after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.ctrl_req = 1'b0;
        bus.ctrl_src = 3'd0;
        bus.ctrl_dst = 5'd0;
        bus.ld_issue = 1'b0;
        bus.ld_dst   = 5'd0;
    endtask

    // Reset, then the init write to r29 and first RUN cycle.
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        bus.ctrl_req = 1'b1;
        bus.ctrl_src = 3'd2;
        bus.ctrl_dst = 5'd3;
        bus.ld_issue = 1'b1;
        #1;
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", bus.rf_we); end
        checks++; if (bus.wd_sel !== 3'd0) begin failures++; $display("FAIL rst_sel got=%0d exp=0", bus.wd_sel); end
        checks++; if (bus.rf_dst !== 5'd0) begin failures++; $display("FAIL rst_dst got=%0d exp=0", bus.rf_dst); end
        checks++; if (bus.ctrl_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0b exp=0", bus.ctrl_ack); end
        checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", bus.ld_ready); end
        checks++; if (bus.init_busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%0b exp=1", bus.init_busy); end
        // First cycle out of reset: INIT_SP, requests still refused.
        reset = 1'b0;
        #1;
        checks++; if (bus.ctrl_ack !== 1'b0) begin failures++; $display("FAIL init_ack got=%0b exp=0", bus.ctrl_ack); end
        checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL init_ready got=%0b exp=0", bus.ld_ready); end
        checks++; if (bus.init_busy !== 1'b1) begin failures++; $display("FAIL init_busy got=%0b exp=1", bus.init_busy); end
        next_cycle();
        idle_inputs();
        checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("FAIL init_wr_we got=%0b exp=1", bus.rf_we); end
        checks++; if (bus.wd_sel !== 3'd7) begin failures++; $display("FAIL init_wr_sel got=%0d exp=7", bus.wd_sel); end
        checks++; if (bus.rf_dst !== 5'd29) begin failures++; $display("FAIL init_wr_dst got=%0d exp=29", bus.rf_dst); end
        next_cycle();
        #1;
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL post_init_we got=%0b exp=0", bus.rf_we); end
        checks++; if (bus.init_busy !== 1'b0) begin failures++; $display("FAIL post_init_busy got=%0b exp=0", bus.init_busy); end
        checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL post_init_ready got=%0b exp=1", bus.ld_ready); end
    endtask

    task automatic test_ctrl_write();
        bus.ctrl_req = 1'b1;
        bus.ctrl_src = 3'd2;
        bus.ctrl_dst = 5'd8;
        #1;
        checks++; if (bus.ctrl_ack !== 1'b1) begin failures++; $display("FAIL ctrl_ack got=%0b exp=1", bus.ctrl_ack); end
        next_cycle();
        idle_inputs();
        checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("FAIL ctrl_we got=%0b exp=1", bus.rf_we); end
        checks++; if (bus.wd_sel !== 3'd2) begin failures++; $display("FAIL ctrl_sel got=%0d exp=2", bus.wd_sel); end
        checks++; if (bus.rf_dst !== 5'd8) begin failures++; $display("FAIL ctrl_dst got=%0d exp=8", bus.rf_dst); end
        next_cycle();
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL ctrl_we_pulse got=%0b exp=0", bus.rf_we); end
        checks++; if (bus.wd_sel !== 3'd2) begin failures++; $display("FAIL ctrl_sel_hold got=%0d exp=2", bus.wd_sel); end
        checks++; if (bus.rf_dst !== 5'd8) begin failures++; $display("FAIL ctrl_dst_hold got=%0d exp=8", bus.rf_dst); end
    endtask

    // Load at N, ignored re-issue at N+1, ctrl from N+2 stalled by the expiring load.
    task automatic test_load_priority();
        bus.ld_issue = 1'b1;
        bus.ld_dst   = 5'd5;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL ld_ready_n got=%0b exp=1", bus.ld_ready); end
        next_cycle();
        bus.ld_dst = 5'd11;
        #1;
        checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL ld_ready_n1 got=%0b exp=0", bus.ld_ready); end
        next_cycle();
        bus.ld_issue = 1'b0;
        bus.ctrl_req = 1'b1;
        bus.ctrl_src = 3'd0;
        bus.ctrl_dst = 5'd9;
        #1;
        checks++; if (bus.ctrl_ack !== 1'b0) begin failures++; $display("FAIL ld_stall_ack got=%0b exp=0", bus.ctrl_ack); end
        checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL ld_ready_n2 got=%0b exp=0", bus.ld_ready); end
        next_cycle();
        checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("FAIL ld_we got=%0b exp=1", bus.rf_we); end
        checks++; if (bus.wd_sel !== 3'd1) begin failures++; $display("FAIL ld_sel got=%0d exp=1", bus.wd_sel); end
        checks++; if (bus.rf_dst !== 5'd5) begin failures++; $display("FAIL ld_dst got=%0d exp=5", bus.rf_dst); end
        checks++; if (bus.ctrl_ack !== 1'b1) begin failures++; $display("FAIL stalled_ack got=%0b exp=1", bus.ctrl_ack); end
        checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL ld_ready_n3 got=%0b exp=1", bus.ld_ready); end
        next_cycle();
        bus.ctrl_req = 1'b0;
        checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("FAIL stalled_we got=%0b exp=1", bus.rf_we); end
        checks++; if (bus.wd_sel !== 3'd0) begin failures++; $display("FAIL stalled_sel got=%0d exp=0", bus.wd_sel); end
        checks++; if (bus.rf_dst !== 5'd9) begin failures++; $display("FAIL stalled_dst got=%0d exp=9", bus.rf_dst); end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL ld_no_second_we cyc=%0d got=%0b exp=0", i, bus.rf_we); end
        end
    endtask

    task automatic test_dst_zero();
        bus.ctrl_req = 1'b1;
        bus.ctrl_src = 3'd3;
        bus.ctrl_dst = 5'd0;
        #1;
        checks++; if (bus.ctrl_ack !== 1'b1) begin failures++; $display("FAIL dst0_ack got=%0b exp=1", bus.ctrl_ack); end
        next_cycle();
        idle_inputs();
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL dst0_ctrl_we got=%0b exp=0", bus.rf_we); end
        bus.ld_issue = 1'b1;
        bus.ld_dst   = 5'd0;
        next_cycle();
        bus.ld_issue = 1'b0;
        next_cycle();
        checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL dst0_ld_pending got=%0b exp=0", bus.ld_ready); end
        next_cycle();
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL dst0_ld_we got=%0b exp=0", bus.rf_we); end
        checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL dst0_ld_clear got=%0b exp=1", bus.ld_ready); end
    endtask

    task automatic test_src7();
        bus.ctrl_req = 1'b1;
        bus.ctrl_src = 3'd7;
        bus.ctrl_dst = 5'd4;
        #1;
        checks++; if (bus.ctrl_ack !== 1'b1) begin failures++; $display("FAIL src7_ack got=%0b exp=1", bus.ctrl_ack); end
        next_cycle();
        idle_inputs();
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL src7_we got=%0b exp=0", bus.rf_we); end
    endtask

    // Two consecutive ctrl grants, the first alongside a load issue.
    task automatic test_back_to_back();
        bus.ctrl_req = 1'b1;
        bus.ctrl_src = 3'd4;
        bus.ctrl_dst = 5'd3;
        bus.ld_issue = 1'b1;
        bus.ld_dst   = 5'd12;
        #1;
        checks++; if (bus.ctrl_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack0 got=%0b exp=1", bus.ctrl_ack); end
        checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", bus.ld_ready); end
        next_cycle();
        bus.ld_issue = 1'b0;
        bus.ctrl_src = 3'd5;
        bus.ctrl_dst = 5'd6;
        #1;
        checks++; if (bus.ctrl_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack1 got=%0b exp=1", bus.ctrl_ack); end
        checks++; if ({bus.rf_we, bus.wd_sel, bus.rf_dst} !== {1'b1, 3'd4, 5'd3}) begin failures++; $display("FAIL b2b_wr0 got=%0b/%0d/%0d exp=1/4/3", bus.rf_we, bus.wd_sel, bus.rf_dst); end
        next_cycle();
        bus.ctrl_req = 1'b0;
        checks++; if ({bus.rf_we, bus.wd_sel, bus.rf_dst} !== {1'b1, 3'd5, 5'd6}) begin failures++; $display("FAIL b2b_wr1 got=%0b/%0d/%0d exp=1/5/6", bus.rf_we, bus.wd_sel, bus.rf_dst); end
        next_cycle();
        checks++; if ({bus.rf_we, bus.wd_sel, bus.rf_dst} !== {1'b1, 3'd1, 5'd12}) begin failures++; $display("FAIL b2b_ld got=%0b/%0d/%0d exp=1/1/12", bus.rf_we, bus.wd_sel, bus.rf_dst); end
        next_cycle();
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0b exp=0", bus.rf_we); end
    endtask

    task automatic test_reset_mid_load();
        bus.ld_issue = 1'b1;
        bus.ld_dst   = 5'd7;
        next_cycle();
        bus.ld_issue = 1'b0;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL mid_rst_we got=%0b exp=0", bus.rf_we); end
        next_cycle();
        checks++; if ({bus.rf_we, bus.wd_sel, bus.rf_dst} !== {1'b1, 3'd7, 5'd29}) begin failures++; $display("FAIL mid_rst_init got=%0b/%0d/%0d exp=1/7/29", bus.rf_we, bus.wd_sel, bus.rf_dst); end
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL mid_rst_no_ld cyc=%0d got=%0b exp=0", i, bus.rf_we); end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_ctrl_write();
        test_load_priority();
        test_dst_zero();
        test_src7();
        test_back_to_back();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
